// File: rtl/ama_riscv_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ama_riscv_pipe_ctrl
// Description : Central pipeline sequencer for the 5-stage AMA-RISCV core.
//               Runs the post-reset pipe-clear sequence, branch/jump
//               stall-and-redirect, load-use bubble insertion and the
//               dmem-busy freeze. All control outputs are combinational from
//               the current state and inputs, so no latency is added.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   RST_SEQ_LEN    cycles after reset release that downstream stages are
//                  held clear (1..7)
//   LDU_STALL_CYC  bubble cycles spent in LDU per load-use hazard (1..3)
//   PERF_W         performance counter width (performance build only)
// Ports
//   clk, rst                         clock, async active-low reset
//   branch_inst_id, jump_inst_id     ID-stage control-flow class flags
//   branch_taken_ex                  EX branch resolution (used in BR_RES)
//   load_inst_ex, rd_ex              EX load flag and destination register
//   rs1_id, rs2_id, rs*_used_id      ID source registers and usage flags
//   dmem_busy                        data memory not ready
//   stall_if/id/ex                   hold PC/IF, ID, EX pipe registers
//   clear_id/ex/mem                  load a NOP into that pipe register
//   pc_start, pc_redirect            PC source selects
//   state                            current FSM state (debug)
//   perf_stall_cyc, perf_flush_cnt,  saturating counters, present only when
//   perf_freeze_cyc                  AMA_RISCV_PIPE_CTRL_PERF_EN is defined
// Build option
//   AMA_RISCV_PIPE_CTRL_PERF_EN      adds the performance counters
// ============================================================================
module ama_riscv_pipe_ctrl #(
  parameter int RST_SEQ_LEN   = 3,
  parameter int LDU_STALL_CYC = 1
`ifdef AMA_RISCV_PIPE_CTRL_PERF_EN
  ,
  parameter int PERF_W        = 32
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_inst_id,
  input  logic        jump_inst_id,
  input  logic        branch_taken_ex,
  input  logic        load_inst_ex,
  input  logic [4:0]  rd_ex,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  input  logic        rs1_used_id,
  input  logic        rs2_used_id,
  input  logic        dmem_busy,
  output logic        stall_if,
  output logic        stall_id,
  output logic        stall_ex,
  output logic        clear_id,
  output logic        clear_ex,
  output logic        clear_mem,
  output logic        pc_start,
  output logic        pc_redirect,
  output logic [2:0]  state
`ifdef AMA_RISCV_PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_stall_cyc,
  output logic [PERF_W-1:0] perf_flush_cnt,
  output logic [PERF_W-1:0] perf_freeze_cyc
`endif
);

  typedef enum logic [2:0] {
    S_RST_SEQ = 3'd0,
    S_RUN     = 3'd1,
    S_BR_RES  = 3'd2,
    S_LDU     = 3'd3,
    S_FREEZE  = 3'd4
  } state_t;

  localparam logic [2:0] c_SEQ_INIT = 3'(RST_SEQ_LEN);
  localparam logic [1:0] c_LDU_INIT = 2'(LDU_STALL_CYC - 1);

  // --------------------------------------------------------------------------
  // Reset synchroniser: assertion is immediate, release is seen on the 2nd
  // rising edge after rst goes high.
  // --------------------------------------------------------------------------
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  // --------------------------------------------------------------------------
  // State and next-state
  // --------------------------------------------------------------------------
  state_t     r_state;
  logic [2:0] r_seq_cnt;
  logic [1:0] r_ldu_cnt;
  logic       r_jump_q;

  state_t     w_state_nxt;
  logic [2:0] w_seq_nxt;
  logic [1:0] w_ldu_nxt;
  logic       w_jump_nxt;
  logic       w_ldu_hazard;
  logic       w_run_eval;
  int         w_seq_cnt_int;

  // A write to x0 is never a real dependency.
  assign w_ldu_hazard = load_inst_ex && (rd_ex != 5'd0) &&
                        ((rs1_used_id && (rs1_id == rd_ex)) ||
                         (rs2_used_id && (rs2_id == rd_ex)));

  // FREEZE releasing behaves exactly like a RUN cycle, so both share the
  // RUN decision logic.
  assign w_run_eval = (r_state == S_RUN) ||
                      ((r_state == S_FREEZE) && !dmem_busy);

  assign w_seq_cnt_int = int'(r_seq_cnt);
  assign state         = r_state;

  always_comb begin
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    stall_ex    = 1'b0;
    clear_id    = 1'b0;
    clear_ex    = 1'b0;
    clear_mem   = 1'b0;
    pc_start    = 1'b0;
    pc_redirect = 1'b0;
    w_state_nxt = r_state;
    w_seq_nxt   = r_seq_cnt;
    w_ldu_nxt   = r_ldu_cnt;
    w_jump_nxt  = r_jump_q;

    if (w_run_eval) begin
      w_state_nxt = S_RUN;
      if (dmem_busy) begin
        stall_if    = 1'b1;
        stall_id    = 1'b1;
        stall_ex    = 1'b1;
        clear_mem   = 1'b1;
        w_state_nxt = S_FREEZE;
      end else if (w_ldu_hazard) begin
        stall_if    = 1'b1;
        stall_id    = 1'b1;
        clear_ex    = 1'b1;
        w_state_nxt = S_LDU;
        w_ldu_nxt   = c_LDU_INIT;
      end else if (branch_inst_id || jump_inst_id) begin
        // The instruction fetched behind the control-flow op is discarded.
        stall_if    = 1'b1;
        clear_id    = 1'b1;
        w_state_nxt = S_BR_RES;
        w_jump_nxt  = jump_inst_id;
      end
    end else begin
      case (r_state)
        S_RST_SEQ: begin
          // Stages are released one per cycle, front to back.
          pc_start  = (r_seq_cnt == c_SEQ_INIT);
          clear_id  = (w_seq_cnt_int > RST_SEQ_LEN - 1);
          clear_ex  = (w_seq_cnt_int > RST_SEQ_LEN - 2);
          clear_mem = (r_seq_cnt != 3'd0);
          if (r_seq_cnt <= 3'd1) begin
            w_state_nxt = S_RUN;
            w_seq_nxt   = 3'd0;
          end else begin
            w_seq_nxt   = r_seq_cnt - 3'd1;
          end
        end

        S_BR_RES: begin
          pc_redirect = r_jump_q || branch_taken_ex;
          clear_id    = r_jump_q || branch_taken_ex;
          if (dmem_busy) begin
            // Redirect is still taken; the rest of the pipe freezes with
            // a bubble behind EX, as in FREEZE.
            stall_if    = 1'b1;
            stall_id    = 1'b1;
            stall_ex    = 1'b1;
            clear_mem   = 1'b1;
            w_state_nxt = S_FREEZE;
          end else begin
            w_state_nxt = S_RUN;
          end
        end

        S_LDU: begin
          if (dmem_busy) begin
            // The load finishes during the freeze, so the remaining
            // bubbles are no longer needed.
            stall_if    = 1'b1;
            stall_id    = 1'b1;
            stall_ex    = 1'b1;
            clear_mem   = 1'b1;
            w_state_nxt = S_FREEZE;
            w_ldu_nxt   = 2'd0;
          end else begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            clear_ex = 1'b1;
            if (r_ldu_cnt == 2'd0) begin
              w_state_nxt = S_RUN;
            end else begin
              w_ldu_nxt   = r_ldu_cnt - 2'd1;
            end
          end
        end

        S_FREEZE: begin
          // Only reached with dmem_busy=1; release goes through w_run_eval.
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          stall_ex  = 1'b1;
          clear_mem = 1'b1;
        end

        default: begin
          w_state_nxt = S_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state   <= S_RST_SEQ;
      r_seq_cnt <= c_SEQ_INIT;
      r_ldu_cnt <= 2'd0;
      r_jump_q  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_seq_cnt <= w_seq_nxt;
      r_ldu_cnt <= w_ldu_nxt;
      r_jump_q  <= w_jump_nxt;
    end
  end

`ifdef AMA_RISCV_PIPE_CTRL_PERF_EN
  // --------------------------------------------------------------------------
  // Saturating performance counters
  // --------------------------------------------------------------------------
  logic [PERF_W-1:0] r_perf_stall;
  logic [PERF_W-1:0] r_perf_flush;
  logic [PERF_W-1:0] r_perf_freeze;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_perf_stall  <= '0;
      r_perf_flush  <= '0;
      r_perf_freeze <= '0;
    end else begin
      if (stall_if && (r_state != S_RST_SEQ) && (r_perf_stall != '1)) begin
        r_perf_stall <= r_perf_stall + 1'b1;
      end
      if (pc_redirect && (r_perf_flush != '1)) begin
        r_perf_flush <= r_perf_flush + 1'b1;
      end
      if ((r_state == S_FREEZE) && (r_perf_freeze != '1)) begin
        r_perf_freeze <= r_perf_freeze + 1'b1;
      end
    end
  end

  assign perf_stall_cyc  = r_perf_stall;
  assign perf_flush_cnt  = r_perf_flush;
  assign perf_freeze_cyc = r_perf_freeze;
`endif

endmodule
`default_nettype wire
